// File: rtl/prm_regbank_arb_pkg.sv
// Shared defaults and helpers for the register-bank write arbiter.
// Imported by the picker and the arbiter top.
package prm_regbank_arb_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int DEPTH_DEF = 8;
  localparam int WIDTH_DEF = 8;

  // Index width for n items; never narrower than one bit.
  function automatic int aw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prm_rr_pick.sv
// Combinational round-robin picker: first set bit of elig at or
// after ptr, wrapping from NREQ-1 back to 0.
module prm_rr_pick
  import prm_regbank_arb_pkg::*;
#(
  parameter  int NREQ = NREQ_DEF,
  localparam int PW   = aw_of(NREQ)
) (
  input  logic [NREQ-1:0] elig,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic [PW-1:0]   idx,
  output logic            any
);

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int c;
      c = (int'(ptr) + k) % NREQ;
      if (!any && elig[c]) begin
        any       = 1'b1;
        idx       = PW'(c);
        onehot[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prm_regbank_arb.sv
// Round-robin write arbiter for a clearable register bank; a bulk
// clear has absolute priority and every bank control is registered.
module prm_regbank_arb
  import prm_regbank_arb_pkg::*;
#(
  parameter  int NREQ  = NREQ_DEF,
  parameter  int DEPTH = DEPTH_DEF,
  parameter  int WIDTH = WIDTH_DEF,
  localparam int AW    = aw_of(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*AW-1:0]    addr,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]   gnt,
  output logic              err,
  output logic [DEPTH-1:0]  reg_we,
  output logic [WIDTH-1:0]  reg_d,
  output logic              reg_clr_n,
  output logic              busy
);

  localparam int PW = aw_of(NREQ);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [NREQ-1:0]  elig;
  logic [NREQ-1:0]  pick_oh;
  logic [PW-1:0]    pick_idx;
  logic             pick_any;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [NREQ-1:0]  gnt_d;
  logic [DEPTH-1:0] we_d;
  logic [WIDTH-1:0] d_d;
  logic [AW-1:0]    a;
  logic             err_d, clr_n_d, busy_d;

  // Masking the current grant stops a double grant while req drops.
  assign elig = req & ~gnt;

  prm_rr_pick #(.NREQ(NREQ)) u_pick (
    .elig   (elig),
    .ptr    (ptr_q),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    gnt_d   = '0;
    we_d    = '0;
    err_d   = 1'b0;
    clr_n_d = 1'b1;
    d_d     = reg_d;
    ptr_d   = ptr_q;
    a       = addr[pick_idx*AW +: AW];
    priority case (1'b1)
      clr_req: clr_n_d = 1'b0;
      pick_any: begin
        gnt_d = pick_oh;
        d_d   = wdata[pick_idx*WIDTH +: WIDTH];
        if ({1'b0, a} < DEPTH_W)
          we_d[a] = 1'b1;
        else
          err_d = 1'b1;
        ptr_d = (pick_idx == PW'(NREQ-1)) ? '0
              : pick_idx + 1'b1;
      end
      default: ;
    endcase
    busy_d = |gnt_d | |we_d | ~clr_n_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt       <= '0;
      reg_we    <= '0;
      reg_d     <= '0;
      err       <= 1'b0;
      reg_clr_n <= 1'b1;
      busy      <= 1'b0;
      ptr_q     <= '0;
    end else begin
      gnt       <= gnt_d;
      reg_we    <= we_d;
      reg_d     <= d_d;
      err       <= err_d;
      reg_clr_n <= clr_n_d;
      busy      <= busy_d;
      ptr_q     <= ptr_d;
    end
  end

endmodule

// File: tb/tb_prm_regbank_arb.sv
// Scoreboard bench for prm_regbank_arb (NREQ=4, DEPTH=6, WIDTH=8).
// Stimulus pushes expected pulses; a monitor pops on every DUT pulse.
module tb_prm_regbank_arb;

  localparam int NREQ  = 4;
  localparam int DEPTH = 6;
  localparam int WIDTH = 8;
  localparam int AW    = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr_req = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*AW-1:0] addr = '0;
  logic [NREQ*WIDTH-1:0] wdata = '0;
  logic [NREQ-1:0] gnt;
  logic err;
  logic [DEPTH-1:0] reg_we;
  logic [WIDTH-1:0] reg_d;
  logic reg_clr_n;
  logic busy;

  prm_regbank_arb #(
    .NREQ(NREQ), .DEPTH(DEPTH), .WIDTH(WIDTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_req   (clr_req),
    .req       (req),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .err       (err),
    .reg_we    (reg_we),
    .reg_d     (reg_d),
    .reg_clr_n (reg_clr_n),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]      cyc;
    logic [NREQ-1:0]  gnt;
    logic [DEPTH-1:0] we;
    logic [WIDTH-1:0] d;
    logic             err;
    logic             clr_n;
  } exp_t;

  exp_t q[$];
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  logic [WIDTH-1:0] last_d = '0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Call right after a negedge: outputs due at the next posedge.
  task automatic expect_pulse(logic [NREQ-1:0] g, logic [DEPTH-1:0] w,
                              logic [WIDTH-1:0] d, logic e, logic cn);
    exp_t x;
    x.cyc = 32'(cyc + 1);
    x.gnt = g;
    x.we = w;
    x.d = d;
    x.err = e;
    x.clr_n = cn;
    last_d = d;
    q.push_back(x);
  endtask

  task automatic expect_clear();
    expect_pulse('0, '0, last_d, 1'b0, 1'b0);
  endtask

  // Monitor: pop and compare whenever the DUT shows any pulse.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (gnt != 0 || reg_we != 0 || err || !reg_clr_n) begin
        if (q.size() == 0) begin
          chk("unexpected_pulse",
              {gnt, reg_we, err, ~reg_clr_n}, 0);
        end else begin
          e = q.pop_front();
          chk("pulse_cycle", 32'(cyc), e.cyc);
          chk("gnt", 32'(gnt), 32'(e.gnt));
          chk("reg_we", 32'(reg_we), 32'(e.we));
          chk("reg_d", 32'(reg_d), 32'(e.d));
          chk("err", 32'(err), 32'(e.err));
          chk("reg_clr_n", 32'(reg_clr_n), 32'(e.clr_n));
          chk("busy_active", 32'(busy), 1);
        end
      end else begin
        chk("busy_idle", 32'(busy), 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  function automatic logic [NREQ*AW-1:0] pack_addr(
      int a0, int a1, int a2, int a3);
    return {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endfunction

  initial begin
    addr  = pack_addr(0, 1, 5, 7);
    wdata = {8'h3C, 8'hA5, 8'h11, 8'h10};
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_we", 32'(reg_we), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_d", 32'(reg_d), 0);
    chk("rst_clr_n", 32'(reg_clr_n), 1);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;

    // Round robin with all four requesting, addr[i]=i.
    addr = pack_addr(0, 1, 2, 3);
    wdata = {8'h13, 8'h12, 8'h11, 8'h10};
    @(negedge clk); req = 4'b1111;
    expect_pulse(4'b0001, 6'b000001, 8'h10, 0, 1);
    @(negedge clk); expect_pulse(4'b0010, 6'b000010, 8'h11, 0, 1);
    @(negedge clk); expect_pulse(4'b0100, 6'b000100, 8'h12, 0, 1);
    @(negedge clk); expect_pulse(4'b1000, 6'b001000, 8'h13, 0, 1);
    @(negedge clk); expect_pulse(4'b0001, 6'b000001, 8'h10, 0, 1);
    @(negedge clk); req = 4'b0000;

    // Single requester: one write every other cycle (ptr 1 -> 3).
    addr = pack_addr(0, 1, 5, 7);
    wdata = {8'h3C, 8'hA5, 8'h11, 8'h10};
    @(negedge clk); req = 4'b0100;
    expect_pulse(4'b0100, 6'b100000, 8'hA5, 0, 1);
    @(negedge clk);
    @(negedge clk); expect_pulse(4'b0100, 6'b100000, 8'hA5, 0, 1);
    @(negedge clk);
    @(negedge clk); expect_pulse(4'b0100, 6'b100000, 8'hA5, 0, 1);
    @(negedge clk); req = 4'b0000;

    // Clear beats pending requests; ptr 3 kept, so 0 wins after.
    @(negedge clk); clr_req = 1'b1; req = 4'b0011;
    expect_clear();
    @(negedge clk); expect_clear();
    @(negedge clk); expect_clear();
    @(negedge clk); clr_req = 1'b0;
    expect_pulse(4'b0001, 6'b000001, 8'h10, 0, 1);
    @(negedge clk); expect_pulse(4'b0010, 6'b000010, 8'h11, 0, 1);
    @(negedge clk); req = 4'b0000;

    // Out-of-range addr 7: grant with err, no write, ptr -> 0.
    @(negedge clk); req = 4'b1000;
    expect_pulse(4'b1000, 6'b000000, 8'h3C, 1, 1);
    @(negedge clk); req = 4'b0000;
    @(negedge clk); req = 4'b1010;
    expect_pulse(4'b0010, 6'b000010, 8'h11, 0, 1);
    @(negedge clk); req = 4'b0000;

    // Move ptr to 3, then withdraw req[3] before it is sampled.
    @(negedge clk); req = 4'b0100;
    expect_pulse(4'b0100, 6'b100000, 8'hA5, 0, 1);
    @(negedge clk); req = 4'b0000;
    @(negedge clk); req = 4'b1000;
    #2 req = 4'b0001;
    expect_pulse(4'b0001, 6'b000001, 8'h10, 0, 1);
    @(negedge clk); req = 4'b0000;
    @(negedge clk); req = 4'b1001;
    expect_pulse(4'b1000, 6'b000000, 8'h3C, 1, 1);
    @(negedge clk); req = 4'b0000;

    // Reset while gnt[1] is high; ptr must restart at 0.
    @(negedge clk); req = 4'b0010;
    expect_pulse(4'b0010, 6'b000010, 8'h11, 0, 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    req = 4'b0000;
    #1;
    chk("mid_rst_gnt", 32'(gnt), 0);
    chk("mid_rst_we", 32'(reg_we), 0);
    chk("mid_rst_err", 32'(err), 0);
    chk("mid_rst_clr_n", 32'(reg_clr_n), 1);
    chk("mid_rst_busy", 32'(busy), 0);
    last_d = '0;
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1; req = 4'b0101;
    expect_pulse(4'b0001, 6'b000001, 8'h10, 0, 1);
    @(negedge clk); expect_pulse(4'b0100, 6'b100000, 8'hA5, 0, 1);
    @(negedge clk); req = 4'b0000;

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
